// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: shares one byte-wide RAM port between instruction fetch
// (32-bit reads) and the load/store buffer (byte/half/word loads and stores).
// Each granted request becomes 1-4 single-byte RAM cycles and finishes with a
// one-cycle ok pulse on the matching requester port.
module mem_access_ctrl #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ok,
  output logic [31:0]       if_data,
  input  logic              ls_load_req,
  input  logic              ls_store_req,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_ok,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE} op_t;

  state_t            state;
  op_t               op;
  logic [2:0]        nbytes;
  logic [2:0]        cnt;
  logic              quiet;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata;
  logic [31:0]       acc;

  logic              if_pend;
  logic [ADDR_W-1:0] if_pend_addr;
  logic              ls_pend;
  logic              ls_pend_store;
  logic              ls_pend_quiet;
  logic [1:0]        ls_pend_size;
  logic [ADDR_W-1:0] ls_pend_addr;
  logic [31:0]       ls_pend_wdata;

  logic              if_take;
  logic              ls_take;
  logic              ls_stall;
  logic              grant_ls;
  logic              grant_if;
  logic [2:0]        cnt_nxt;
  logic [1:0]        rd_idx;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] insert_byte(input logic [31:0] word, input logic [1:0] idx,
                                              input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = b;
    return w;
  endfunction

  // Request acceptance and arbitration; a stalled IO store lets fetch through.
  always_comb begin
    if_take  = if_req && rdy && !clear;
    ls_take  = (ls_load_req || ls_store_req) && rdy && !clear;
    ls_stall = ls_pend_store && (ls_pend_addr[17:16] == IO_HI) && io_buffer_full;
    grant_ls = (state == IDLE) && rdy && ls_pend && !ls_stall && (ls_pend_store || !clear);
    grant_if = (state == IDLE) && rdy && !grant_ls && if_pend && !clear;
    cnt_nxt  = cnt + 3'd1;
    rd_idx   = cnt[1:0] - 2'd1;
  end

  // Pending-slot payloads, latched transaction data and read-byte assembly.
  always_ff @(posedge clk) begin
    if (if_take) if_pend_addr <= if_addr;
    if (ls_take) begin
      ls_pend_addr  <= ls_addr;
      ls_pend_size  <= ls_size;
      ls_pend_wdata <= ls_wdata;
    end
    if (grant_ls) begin
      base  <= ls_pend_addr;
      wdata <= ls_pend_wdata;
    end else if (grant_if) begin
      base  <= if_pend_addr;
    end
    if (grant_ls || grant_if)
      acc <= '0;
    else if (state == BUSY && cnt_nxt >= 3'd2)
      acc <= insert_byte(acc, rd_idx, mem_din);
  end

  // Pending flags, IDLE/BUSY sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op            <= OP_FETCH;
      nbytes        <= 3'd4;
      cnt           <= '0;
      quiet         <= 1'b0;
      if_pend       <= 1'b0;
      ls_pend       <= 1'b0;
      ls_pend_store <= 1'b0;
      ls_pend_quiet <= 1'b0;
      if_ok         <= 1'b0;
      ls_ok         <= 1'b0;
      if_data       <= '0;
      ls_rdata      <= '0;
      mem_a         <= '0;
      mem_dout      <= '0;
      mem_wr        <= 1'b0;
    end else begin
      if_ok <= 1'b0;
      ls_ok <= 1'b0;

      if (if_take)                 if_pend <= 1'b1;
      else if (grant_if || clear)  if_pend <= 1'b0;

      // A flush drops a pending load but only silences a pending store.
      if (ls_take) begin
        ls_pend       <= 1'b1;
        ls_pend_store <= ls_store_req;
        ls_pend_quiet <= 1'b0;
      end else if (grant_ls) begin
        ls_pend <= 1'b0;
      end else if (clear) begin
        if (!ls_pend_store) ls_pend <= 1'b0;
        ls_pend_quiet <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_ls) begin
            state  <= BUSY;
            op     <= ls_pend_store ? OP_STORE : OP_LOAD;
            nbytes <= size_bytes(ls_pend_size);
            cnt    <= '0;
            quiet  <= ls_pend_quiet || clear;
            mem_a  <= ls_pend_addr;
            mem_wr <= ls_pend_store;
            if (ls_pend_store) mem_dout <= ls_pend_wdata[7:0];
          end else if (grant_if) begin
            state  <= BUSY;
            op     <= OP_FETCH;
            nbytes <= 3'd4;
            cnt    <= '0;
            quiet  <= 1'b0;
            mem_a  <= if_pend_addr;
            mem_wr <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt_nxt;
          if (op == OP_STORE) begin
            // Stores always run to completion; a flush only mutes the ok.
            if (clear) quiet <= 1'b1;
            if (cnt_nxt == nbytes) begin
              mem_wr <= 1'b0;
              ls_ok  <= !(quiet || clear);
              state  <= IDLE;
            end else begin
              mem_a    <= base + ADDR_W'(cnt_nxt);
              mem_dout <= pick_byte(wdata, cnt_nxt[1:0]);
            end
          end else if (clear) begin
            state <= IDLE;
          end else begin
            if (cnt_nxt < nbytes) mem_a <= base + ADDR_W'(cnt_nxt);
            // Read data trails the address by one cycle, so the last byte
            // lands one edge after the last address was sampled.
            if (cnt_nxt == nbytes + 3'd1) begin
              state <= IDLE;
              if (op == OP_FETCH) begin
                if_ok   <= 1'b1;
                if_data <= insert_byte(acc, rd_idx, mem_din);
              end else begin
                ls_ok    <= 1'b1;
                ls_rdata <= insert_byte(acc, rd_idx, mem_din);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: byte-wide RAM model, table of directed
// transactions, hand-written flush/stall/reset sequences and a randomized
// run checked against a transaction-level memory model.
module tb_mem_access_ctrl;

  localparam int FETCH = 0;
  localparam int LOAD  = 1;
  localparam int STORE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ok;
  logic [31:0] if_data;
  logic        ls_load_req = 1'b0;
  logic        ls_store_req = 1'b0;
  logic [1:0]  ls_size = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_ok;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_ok(if_ok), .if_data(if_data),
    .ls_load_req(ls_load_req), .ls_store_req(ls_store_req), .ls_size(ls_size),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ok(ls_ok), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // Power-on RAM contents: a few fixed bytes, a pattern elsewhere.
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h78;
      32'h0000_0101: return 8'h56;
      32'h0000_0102: return 8'h34;
      32'h0000_0103: return 8'h12;
      32'h0000_1FFE: return 8'hAA;
      32'h0000_1FFF: return 8'hBB;
      32'hFFFF_FFFE: return 8'h01;
      32'hFFFF_FFFF: return 8'h02;
      32'h0000_0000: return 8'h03;
      32'h0000_0001: return 8'h04;
      32'h0000_0002: return 8'h05;
      32'h0000_0003: return 8'h06;
      default:       return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [15:0] ridx(input logic [31:0] a);
    return {a[15:14] ^ a[17:16], a[13:0]};
  endfunction

  logic [7:0] ram   [0:65535];
  bit         wrote [0:65535];
  logic [7:0] mdl   [0:65535];
  bit         mdl_v [0:65535];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return wrote[ridx(a)] ? ram[ridx(a)] : init_byte(a);
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return mdl_v[ridx(a)] ? mdl[ridx(a)] : init_byte(a);
  endfunction

  // Synchronous byte RAM: samples address/data each edge, read data one cycle later.
  always @(posedge clk) begin
    if (mem_wr) begin
      ram[ridx(mem_a)]   <= mem_dout;
      wrote[ridx(mem_a)] <= 1'b1;
    end
    mem_din <= ram_rd(mem_a);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc = 0;
  int if_ok_cnt = 0;
  int ls_ok_cnt = 0;
  int wr_cnt = 0;
  int if_ok_at = 0;
  int ls_ok_at = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_ls = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
    if (if_ok) begin if_ok_cnt++; if_ok_at = ncyc; last_if = if_data; end
    if (ls_ok) begin ls_ok_cnt++; ls_ok_at = ncyc; last_ls = ls_rdata; end
    if (mem_wr) wr_cnt++;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " if_ok"},    32'(if_ok),    32'h0);
    check({tag, " ls_ok"},    32'(ls_ok),    32'h0);
    check({tag, " if_data"},  if_data,       32'h0);
    check({tag, " ls_rdata"}, ls_rdata,      32'h0);
    check({tag, " mem_a"},    mem_a,         32'h0);
    check({tag, " mem_dout"}, 32'(mem_dout), 32'h0);
    check({tag, " mem_wr"},   32'(mem_wr),   32'h0);
  endtask

  // Issue one request pulse and wait (bounded) for its ok; lat counts edges
  // from the edge that samples the pulse to the edge that raises ok.
  task automatic do_txn(input int kind, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wd, input bit wiggle,
                        output logic [31:0] data, output int lat, output int wrs);
    int wr0;
    bit done;
    wr0 = wr_cnt; done = 1'b0; data = '0; lat = -1;
    if (kind == FETCH) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_addr = addr; ls_size = size; ls_wdata = wd;
      if (kind == STORE) ls_store_req = 1'b1;
      else ls_load_req = 1'b1;
    end
    for (int k = 1; k <= 40 && !done; k++) begin
      tick();
      if_req = 1'b0; ls_load_req = 1'b0; ls_store_req = 1'b0;
      if ((kind == FETCH) ? if_ok : ls_ok) begin
        done = 1'b1;
        lat  = k - 1;
        data = (kind == FETCH) ? if_data : ls_rdata;
      end else if (wiggle && k >= 2) begin
        rdy = ($urandom_range(0, 1) != 0);
      end
    end
    rdy = 1'b1;
    wrs = wr_cnt - wr0;
  endtask

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wd;
    logic [31:0] exp;
    int          lat;
    int          wrs;
  } vec_t;

  vec_t vt [11];

  initial begin
    logic [31:0] d;
    int lat, wrs, c_if, c_ls, wr0, t0, t_rel;

    vt[0]  = '{FETCH, 32'h0000_0100, 2'd2, 32'h0,         32'h1234_5678, 6, 0};
    vt[1]  = '{LOAD,  32'h0000_0101, 2'd0, 32'h0,         32'h0000_0056, 3, 0};
    vt[2]  = '{LOAD,  32'h0000_0102, 2'd1, 32'h0,         32'h0000_1234, 4, 0};
    vt[3]  = '{STORE, 32'h0000_0200, 2'd2, 32'hDEAD_BEEF, 32'h0,         5, 4};
    vt[4]  = '{LOAD,  32'h0000_0200, 2'd2, 32'h0,         32'hDEAD_BEEF, 6, 0};
    vt[5]  = '{STORE, 32'h0000_0300, 2'd1, 32'h1234_CAFE, 32'h0,         3, 2};
    vt[6]  = '{STORE, 32'h0000_0302, 2'd0, 32'h0000_AB77, 32'h0,         2, 1};
    vt[7]  = '{LOAD,  32'h0000_0300, 2'd2, 32'h0,         32'h5A77_CAFE, 6, 0};
    vt[8]  = '{LOAD,  32'hFFFF_FFFE, 2'd2, 32'h0,         32'h0403_0201, 6, 0};
    vt[9]  = '{LOAD,  32'h0000_1FFF, 2'd1, 32'h0,         32'h0000_7ABB, 4, 0};
    vt[10] = '{FETCH, 32'hFFFF_FFFF, 2'd2, 32'h0,         32'h0504_0302, 6, 0};

    // Reset state
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Directed transaction table
    for (int i = 0; i < 11; i++) begin
      do_txn(vt[i].kind, vt[i].addr, vt[i].size, vt[i].wd, 1'b0, d, lat, wrs);
      if (vt[i].kind != STORE) check($sformatf("vec%0d data", i), d, vt[i].exp);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
      check($sformatf("vec%0d writes", i), 32'(wrs), 32'(vt[i].wrs));
      tick();
    end
    check("store word bytes", {ram_rd(32'h203), ram_rd(32'h202), ram_rd(32'h201), ram_rd(32'h200)},
          32'hDEAD_BEEF);

    // Simultaneous half load and fetch: load first, fetch one IDLE cycle later
    c_if = if_ok_cnt; c_ls = ls_ok_cnt; t0 = ncyc;
    if_req = 1'b1; if_addr = 32'h0;
    ls_load_req = 1'b1; ls_addr = 32'h1FFE; ls_size = 2'd1;
    tick();
    if_req = 1'b0; ls_load_req = 1'b0;
    for (int k = 0; k < 30 && if_ok_cnt == c_if; k++) tick();
    repeat (5) tick();
    check("dual ls_ok count", 32'(ls_ok_cnt - c_ls), 32'd1);
    check("dual if_ok count", 32'(if_ok_cnt - c_if), 32'd1);
    check("dual ls_rdata", last_ls, 32'h0000_BBAA);
    check("dual if_data", last_if, 32'h0605_0403);
    check("dual ls_ok time", 32'(ls_ok_at - t0), 32'd5);
    check("dual fetch after load", 32'(if_ok_at - ls_ok_at), 32'd6);

    // IO store stalled by a full buffer while a fetch is served
    c_if = if_ok_cnt; c_ls = ls_ok_cnt; wr0 = wr_cnt;
    io_buffer_full = 1'b1;
    ls_store_req = 1'b1; ls_addr = 32'h0003_0000; ls_size = 2'd0; ls_wdata = 32'h0000_005C;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    ls_store_req = 1'b0; if_req = 1'b0;
    repeat (9) tick();
    check("io stall writes", 32'(wr_cnt - wr0), 32'd0);
    check("io stall fetch served", 32'(if_ok_cnt - c_if), 32'd1);
    check("io stall fetch data", last_if, 32'h1234_5678);
    check("io stall no ls_ok", 32'(ls_ok_cnt - c_ls), 32'd0);
    io_buffer_full = 1'b0;
    t_rel = ncyc;
    for (int k = 0; k < 20 && ls_ok_cnt == c_ls; k++) tick();
    check("io store ok delay", 32'(ls_ok_at - t_rel), 32'd2);
    check("io store writes", 32'(wr_cnt - wr0), 32'd1);
    check("io store byte", 32'(ram_rd(32'h0003_0000)), 32'h5C);
    tick();

    // Pulse with rdy low is ignored
    c_if = if_ok_cnt;
    rdy = 1'b0; if_req = 1'b1; if_addr = 32'h100;
    tick();
    rdy = 1'b1; if_req = 1'b0;
    repeat (10) tick();
    check("rdy low ignored", 32'(if_ok_cnt - c_if), 32'd0);

    // Flush one cycle after a word load is granted
    c_ls = ls_ok_cnt;
    ls_load_req = 1'b1; ls_addr = 32'h100; ls_size = 2'd2;
    tick();
    ls_load_req = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (8) tick();
    check("flush load mem_a held", mem_a, 32'h100);
    check("flush load no ls_ok", 32'(ls_ok_cnt - c_ls), 32'd0);
    do_txn(FETCH, 32'h100, 2'd2, 32'h0, 1'b0, d, lat, wrs);
    check("post flush fetch data", d, 32'h1234_5678);
    check("post flush fetch latency", 32'(lat), 32'd6);
    tick();

    // Flush in the middle of a word store
    c_ls = ls_ok_cnt; wr0 = wr_cnt;
    ls_store_req = 1'b1; ls_addr = 32'h500; ls_size = 2'd2; ls_wdata = 32'h0102_0304;
    tick();
    ls_store_req = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (8) tick();
    check("flush store writes", 32'(wr_cnt - wr0), 32'd4);
    check("flush store no ls_ok", 32'(ls_ok_cnt - c_ls), 32'd0);
    check("flush store bytes", {ram_rd(32'h503), ram_rd(32'h502), ram_rd(32'h501), ram_rd(32'h500)},
          32'h0102_0304);

    // Reset in the middle of a store
    ls_store_req = 1'b1; ls_addr = 32'h600; ls_size = 2'd2; ls_wdata = 32'hA5A5_A5A5;
    tick();
    ls_store_req = 1'b0;
    tick();
    check("mid store mem_wr", 32'(mem_wr), 32'h1);
    rst = 1'b1;
    tick();
    check_reset("mid reset");
    rst = 1'b0;
    tick();
    do_txn(FETCH, 32'h100, 2'd2, 32'h0, 1'b0, d, lat, wrs);
    check("post reset fetch data", d, 32'h1234_5678);
    tick();

    // Randomized transactions against a transaction-level memory model
    for (int i = 0; i < 40; i++) begin
      int kind, n;
      logic [1:0]  sz;
      logic [31:0] a, wd, exp;
      kind = int'($urandom_range(0, 2));
      sz   = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = 32'h0000_4000 + 32'($urandom_range(0, 255));
      wd = $urandom;
      n  = (kind == FETCH) ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      exp = '0;
      for (int b = 0; b < n; b++) exp[8*b +: 8] = mdl_rd(a + 32'(b));
      do_txn(kind, a, sz, wd, 1'b1, d, lat, wrs);
      if (kind == STORE) begin
        for (int b = 0; b < n; b++) begin
          mdl[ridx(a + 32'(b))]   = wd[8*b +: 8];
          mdl_v[ridx(a + 32'(b))] = 1'b1;
        end
        check($sformatf("rnd%0d store latency", i), 32'(lat), 32'(n + 1));
        check($sformatf("rnd%0d store writes", i), 32'(wrs), 32'(n));
      end else begin
        check($sformatf("rnd%0d read data", i), d, exp);
        check($sformatf("rnd%0d read latency", i), 32'(lat), 32'(n + 2));
        check($sformatf("rnd%0d read writes", i), 32'(wrs), 32'd0);
      end
      if ($urandom_range(0, 1) != 0) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
